// File: rtl/uart_tx_stream.sv
// rtl/uart_tx_stream.sv - parametrised UART transmitter with stream input FIFO
//
// Purpose: accepts characters on a valid/ready stream, buffers them in a
// circular FIFO and serialises them as start / data (LSB first) / optional
// parity / stop bits on tx. Frames run back to back while characters are
// queued, CTS is asserted and tx_enable is high.
//
// Ports:
//   clk        - clock, rising edge
//   rstn       - asynchronous active-low reset
//   s_valid    - producer offers s_data
//   s_ready    - FIFO not full
//   s_data     - character, LSB sent first
//   cts_n      - asynchronous clear-to-send, active-low
//   tx_enable  - gates the start of new frames
//   tx         - serial line, idle high, registered
//   tx_busy    - frame in progress
//   fifo_level - occupied FIFO entries
module uart_tx_stream #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int CLK_FREQ_HZ = 125000000,
  parameter int BAUDRATE    = 9600,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_WIDTH-1:0]         s_data,
  input  logic                          cts_n,
  input  logic                          tx_enable,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DIV = CLK_FREQ_HZ / BAUDRATE;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int BW  = $clog2(DIV);
  localparam int CW  = 4;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]         level_q, level_d;
  logic                  push, pop;
  logic                  cts_meta_q, cts_s_q;
  state_e                state_q, state_d;
  logic [BW-1:0]         baud_q, baud_d;
  logic [CW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  eligible, bit_end;
  logic [DATA_WIDTH-1:0] head;

  assign s_ready    = (level_q != LW'(FIFO_DEPTH));
  assign push       = s_valid && s_ready;
  assign head       = mem_q[rd_ptr_q];
  assign fifo_level = level_q;
  assign tx         = tx_q;
  assign tx_busy    = (state_q != S_IDLE);
  assign eligible   = (level_q != '0) && !cts_s_q && tx_enable;
  assign bit_end    = (baud_q == BW'(DIV - 1));

  // Storage needs no reset: pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (eligible) begin
          pop     = 1'b1;
          state_d = S_START;
          shift_d = head;
          par_d   = (^head) ^ (PARITY == 2);
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == CW'(DATA_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_d = bit_q + CW'(1);
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == CW'(STOP_BITS - 1)) begin
            bit_d = '0;
            // Chain straight into the next start bit so there is no idle gap.
            if (eligible) begin
              pop     = 1'b1;
              state_d = S_START;
              shift_d = head;
              par_d   = (^head) ^ (PARITY == 2);
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // tx is registered from next-state values so the line changes in the
    // same cycle the state does.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      S_PAR:   tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      cts_meta_q <= 1'b1;
      cts_s_q    <= 1'b1;
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q    <= level_d;
      cts_meta_q <= cts_n;
      cts_s_q    <= cts_meta_q;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
    end
  end

endmodule
